video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised raster timing generator that produces horizontal sync, vertical sync, data enable, pixel coordinates and frame/line start strobes for the HDMI output path. It supersedes the single-compare horizontal pulse with a full line and frame sequencer. Active, front-porch, sync and back-porch lengths are run-time inputs. Sync polarity is a build-time parameter. It sits between the pixel clock domain and the overlay/pixel-fetch logic, which uses `dataEnable`, `pixelX` and `pixelY` to address image data.

## Interface
- `busWidth`, 12: width of every timing input and of the coordinate outputs.
- `H_SYNC_ACTIVE_HIGH`, 1: 1 means `hSyncOut` is high during sync; 0 means it is low during sync.
- `V_SYNC_ACTIVE_HIGH`, 1: same as above, for `vSyncOut`.

- `clock`  in  1  pixel clock; all logic is on its rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; low means idle.
- `hActive`, `hFront`, `hSync`, `hBack`  in  busWidth each  horizontal region lengths, in pixels.
- `vActive`, `vFront`, `vSync`, `vBack`  in  busWidth each  vertical region lengths, in lines.
- `hSyncOut`  out  1  horizontal sync, at parameter polarity.
- `vSyncOut`  out  1  vertical sync, at parameter polarity.
- `dataEnable`  out  1  high in the active pixel area.
- `pixelX`  out  busWidth  horizontal count.
- `pixelY`  out  busWidth  vertical count.
- `lineStart`  out  1  one-cycle strobe at horizontal count 0.
- `frameStart`  out  1  one-cycle strobe at horizontal count 0 and vertical count 0.

## Operation

**States**
- IDLE, then RUN.
- IDLE → RUN when `enable` is 1 and `hTotal` ≠ 0 and `vTotal` ≠ 0.
- RUN → IDLE when `enable` is 0.

**Shadow configuration**
- All eight timing inputs are copied into shadow registers on every cycle in IDLE.
- In RUN they are copied only on the frame-wrap cycle (hCount = hTotal−1 and vCount = vTotal−1).
- Input changes mid-frame have no effect until the next frame.

**Totals**
- hTotal = hActive + hFront + hSync + hBack, and vTotal likewise, both computed from the shadow registers.
- The sum is (busWidth+2) bits wide, so it never overflows.
- Internal counters are (busWidth+2) bits wide.
- `pixelX`/`pixelY` are the low busWidth bits of the counters.

**Counters**
- hCount counts 0 … hTotal−1, then wraps to 0.
- vCount increments on each h-wrap and counts 0 … vTotal−1, then wraps to 0.
- In IDLE both counters are held at 0.

**Region decode (horizontal; vertical is identical using vCount)**
- Active: [0, A).
- Front porch: [A, A+F).
- Sync: [A+F, A+F+S).
- Back porch: [A+F+S, Total).

**Outputs**
- `dataEnable` = h-active AND v-active.
- `hSyncOut` is at sync level while in the h-sync region.
- `vSyncOut` is at sync level for whole lines in the v-sync region; it changes only at hCount = 0.
- Any region length may be 0; that region is then simply skipped.
  - hSync = 0: `hSyncOut` never pulses.
  - hActive = 0 or vActive = 0: `dataEnable` stays 0.

**Reset and disable**
- Reset (`nReset` low, any time, including mid-frame):
  - state = IDLE, counters = 0, shadow registers = 0.
  - `dataEnable`, `lineStart`, `frameStart` = 0; `pixelX`, `pixelY` = 0.
  - `hSyncOut` = !H_SYNC_ACTIVE_HIGH and `vSyncOut` = !V_SYNC_ACTIVE_HIGH (the inactive levels).
- Deasserting `enable` mid-frame aborts the frame.
  - Counters return to 0.
  - On the next cycle all outputs take their reset values.
- Re-enabling always restarts at frame start, using freshly latched configuration.

## Timing
- All outputs are registered, decoded from counter state with 1-cycle latency.
- Outputs in cycle n+1 describe counter values from cycle n, and all outputs are mutually aligned.
- First RUN cycle has counters at (0,0). On the next edge `frameStart` = `lineStart` = 1, and `dataEnable` = 1 if hActive > 0 and vActive > 0.
- `frameStart` and `lineStart` are high for exactly one cycle each.
  - `lineStart` period = hTotal cycles.
  - `frameStart` period = hTotal × vTotal cycles.
- Entry into IDLE from RUN takes one edge; outputs are inactive on the following cycle.
- If `enable` rises with both totals 0, the block stays in IDLE with no output activity.
- Reset is asynchronous: outputs go to their reset values immediately, not at a clock edge.

## Test plan
- **Small raster:** h = 4/1/2/1 (hTotal 8), v = 3/1/1/1 (vTotal 6), both polarities high.
  - `frameStart` every 48 cycles; `lineStart` every 8 cycles.
  - `dataEnable` high at `pixelX` 0–3 on lines 0–2 only: 12 cycles per frame.
  - `hSyncOut` high at X = 5–6; `vSyncOut` high for all of line 4.
- **Negative polarity build (both parameters 0):**
  - During reset, `hSyncOut` = `vSyncOut` = 1.
  - Sync regions drive 0 at the same positions as the small-raster case.
- **Mid-frame configuration change:** change hActive from 4 to 6 at frame cycle 20.
  - Current frame stays at hTotal 8.
  - From the next `frameStart`, `lineStart` spacing is 10.
- **Zero-length regions:** hSync = 0, vFront = 0, hBack = 0.
  - `hSyncOut` never asserts; hTotal = 5.
  - vSync occupies line vActive directly after active video.
- **Disable mid-frame:** drop `enable` at frame cycle 30.
  - Next cycle: `dataEnable` = 0, `pixelX` = `pixelY` = 0, syncs inactive.
  - Re-enable: `frameStart` asserts 1 cycle after the first RUN cycle.
- **Async reset mid-line:** pulse `nReset` low for less than one clock period at frame cycle 13.
  - Outputs take reset values before the next edge.
  - After release with `enable` = 1, a clean frame restarts with `frameStart`.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: run request and region lengths toward the generator,
// sync/enable/coordinate/strobe outputs back toward the pixel consumers.
interface video_timing_gen_if #(
  parameter int busWidth = 12
);
  logic                enable;
  logic [busWidth-1:0] hActive;
  logic [busWidth-1:0] hFront;
  logic [busWidth-1:0] hSync;
  logic [busWidth-1:0] hBack;
  logic [busWidth-1:0] vActive;
  logic [busWidth-1:0] vFront;
  logic [busWidth-1:0] vSync;
  logic [busWidth-1:0] vBack;
  logic                hSyncOut;
  logic                vSyncOut;
  logic                dataEnable;
  logic [busWidth-1:0] pixelX;
  logic [busWidth-1:0] pixelY;
  logic                lineStart;
  logic                frameStart;

  // Generator side: consumes configuration, drives timing.
  modport master (
    input  enable, hActive, hFront, hSync, hBack, vActive, vFront, vSync, vBack,
    output hSyncOut, vSyncOut, dataEnable, pixelX, pixelY, lineStart, frameStart
  );

  // Consumer side: supplies configuration, observes timing.
  modport slave (
    output enable, hActive, hFront, hSync, hBack, vActive, vFront, vSync, vBack,
    input  hSyncOut, vSyncOut, dataEnable, pixelX, pixelY, lineStart, frameStart
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: line/frame sequencer with run-time region lengths,
// frame-synchronous shadow configuration and registered timing outputs.
module video_timing_gen #(
  parameter int busWidth           = 12,
  parameter bit H_SYNC_ACTIVE_HIGH = 1'b1,
  parameter bit V_SYNC_ACTIVE_HIGH = 1'b1
) (
  input logic                clock,
  input logic                nReset,
  video_timing_gen_if.master vif
);

  // Counters and totals carry two extra bits so a sum of four lengths never wraps.
  localparam int CW = busWidth + 2;
  localparam logic [0:0]    IDLE       = 1'b0;
  localparam logic [0:0]    RUN        = 1'b1;
  localparam logic          H_IDLE_LVL = ~H_SYNC_ACTIVE_HIGH;
  localparam logic          V_IDLE_LVL = ~V_SYNC_ACTIVE_HIGH;
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [CW-1:0] ext(input logic [busWidth-1:0] v);
    return {2'b00, v};
  endfunction

  logic [0:0]          state_r;
  logic [busWidth-1:0] sh_h_active_r, sh_h_front_r, sh_h_sync_r, sh_h_back_r;
  logic [busWidth-1:0] sh_v_active_r, sh_v_front_r, sh_v_sync_r, sh_v_back_r;
  logic [CW-1:0]       h_cnt_r, v_cnt_r;
  logic [CW-1:0]       h_total_s, v_total_s, in_h_total_s, in_v_total_s;
  logic [CW-1:0]       h_sync_start_s, h_sync_end_s, v_sync_start_s, v_sync_end_s;
  logic                h_last_s, v_last_s, frame_wrap_s, run_s, start_s, load_s;
  logic                h_act_s, v_act_s, h_sync_s, v_sync_s;

  // Totals, region boundaries, wrap/start/load conditions and region decode.
  always_comb begin
    h_total_s      = ext(sh_h_active_r) + ext(sh_h_front_r) + ext(sh_h_sync_r) + ext(sh_h_back_r);
    v_total_s      = ext(sh_v_active_r) + ext(sh_v_front_r) + ext(sh_v_sync_r) + ext(sh_v_back_r);
    in_h_total_s   = ext(vif.hActive) + ext(vif.hFront) + ext(vif.hSync) + ext(vif.hBack);
    in_v_total_s   = ext(vif.vActive) + ext(vif.vFront) + ext(vif.vSync) + ext(vif.vBack);
    h_sync_start_s = ext(sh_h_active_r) + ext(sh_h_front_r);
    h_sync_end_s   = h_sync_start_s + ext(sh_h_sync_r);
    v_sync_start_s = ext(sh_v_active_r) + ext(sh_v_front_r);
    v_sync_end_s   = v_sync_start_s + ext(sh_v_sync_r);
    // ">=" keeps a zero total (reloaded at a frame wrap) from running the counter away.
    h_last_s       = (h_cnt_r + CNT_ONE) >= h_total_s;
    v_last_s       = (v_cnt_r + CNT_ONE) >= v_total_s;
    frame_wrap_s   = h_last_s && v_last_s;
    run_s          = (state_r == RUN) && vif.enable;
    // Start qualifies on the live inputs because the shadows load on the same edge.
    start_s        = vif.enable && (in_h_total_s != CNT_ZERO) && (in_v_total_s != CNT_ZERO);
    load_s         = (state_r != RUN) || frame_wrap_s;
    h_act_s        = h_cnt_r < ext(sh_h_active_r);
    v_act_s        = v_cnt_r < ext(sh_v_active_r);
    h_sync_s       = (h_cnt_r >= h_sync_start_s) && (h_cnt_r < h_sync_end_s);
    v_sync_s       = (v_cnt_r >= v_sync_start_s) && (v_cnt_r < v_sync_end_s);
  end

  // IDLE/RUN sequencer.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= start_s ? RUN : IDLE;
        RUN:     state_r <= vif.enable ? RUN : IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Shadow configuration: tracks inputs while idle, otherwise only at frame wrap.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      sh_h_active_r <= '0; sh_h_front_r <= '0; sh_h_sync_r <= '0; sh_h_back_r <= '0;
      sh_v_active_r <= '0; sh_v_front_r <= '0; sh_v_sync_r <= '0; sh_v_back_r <= '0;
    end else if (load_s) begin
      sh_h_active_r <= vif.hActive; sh_h_front_r <= vif.hFront;
      sh_h_sync_r   <= vif.hSync;   sh_h_back_r  <= vif.hBack;
      sh_v_active_r <= vif.vActive; sh_v_front_r <= vif.vFront;
      sh_v_sync_r   <= vif.vSync;   sh_v_back_r  <= vif.vBack;
    end
  end

  // Pixel and line counters; held at the origin whenever not running.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      h_cnt_r <= CNT_ZERO;
      v_cnt_r <= CNT_ZERO;
    end else if (!run_s) begin
      h_cnt_r <= CNT_ZERO;
      v_cnt_r <= CNT_ZERO;
    end else if (h_last_s) begin
      h_cnt_r <= CNT_ZERO;
      v_cnt_r <= v_last_s ? CNT_ZERO : (v_cnt_r + CNT_ONE);
    end else begin
      h_cnt_r <= h_cnt_r + CNT_ONE;
    end
  end

  // Registered outputs, one cycle behind the counters; inactive levels when not running.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      vif.hSyncOut   <= H_IDLE_LVL;
      vif.vSyncOut   <= V_IDLE_LVL;
      vif.dataEnable <= 1'b0;
      vif.pixelX     <= '0;
      vif.pixelY     <= '0;
      vif.lineStart  <= 1'b0;
      vif.frameStart <= 1'b0;
    end else if (run_s) begin
      vif.hSyncOut   <= h_sync_s ^ H_IDLE_LVL;
      vif.vSyncOut   <= v_sync_s ^ V_IDLE_LVL;
      vif.dataEnable <= h_act_s && v_act_s;
      vif.pixelX     <= h_cnt_r[busWidth-1:0];
      vif.pixelY     <= v_cnt_r[busWidth-1:0];
      vif.lineStart  <= (h_cnt_r == CNT_ZERO);
      vif.frameStart <= (h_cnt_r == CNT_ZERO) && (v_cnt_r == CNT_ZERO);
    end else begin
      vif.hSyncOut   <= H_IDLE_LVL;
      vif.vSyncOut   <= V_IDLE_LVL;
      vif.dataEnable <= 1'b0;
      vif.pixelX     <= '0;
      vif.pixelY     <= '0;
      vif.lineStart  <= 1'b0;
      vif.frameStart <= 1'b0;
    end
  end

endmodule
